// File: rtl/spi_flash_rd_seq.sv
// Flash read sequencer: polls RDSR1 until WIP clears, then issues READ (0x03)
// and streams the returned bytes, driving a byte-wide SPI engine over req/done.
module spi_flash_rd_seq #(
  parameter int LEN_W     = 8,
  parameter int POLL_GAP  = 16,
  parameter int MAX_POLLS = 255
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_start,
  input  logic [23:0]      i_addr,
  input  logic [LEN_W-1:0] i_len,
  output logic             o_busy,
  output logic             o_done,
  output logic             o_timeout,
  output logic [7:0]       o_rd_data,
  output logic             o_rd_valid,
  output logic             o_xfer_req,
  output logic [7:0]       o_xfer_tx,
  output logic             o_xfer_last,
  input  logic             i_xfer_done,
  input  logic [7:0]       i_xfer_rx
);

  typedef enum logic [3:0] {
    IDLE, S_CMD, S_RSP, S_GAP, R_CMD, R_A2, R_A1, R_A0, R_DAT, FIN
  } state_t;

  localparam int GAP_W = (POLL_GAP > 1) ? $clog2(POLL_GAP) : 1;
  localparam logic [GAP_W-1:0] GAP_LAST  = GAP_W'(POLL_GAP - 1);
  localparam logic [7:0]       POLL_LAST = 8'(MAX_POLLS);

  state_t           state_q, state_d;
  logic [23:0]      addr_q, addr_d;
  logic [LEN_W-1:0] rem_q, rem_d;
  logic [7:0]       poll_q, poll_d;
  logic [GAP_W-1:0] gap_q, gap_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             timeout_q, timeout_d;
  logic [7:0]       rd_data_q, rd_data_d;
  logic             rd_valid_q, rd_valid_d;
  logic             req_q, req_d;
  logic [7:0]       tx_q, tx_d;
  logic             last_q, last_d;

  // Each transfer state raises req while it is low, then advances on done;
  // the fall of req on done guarantees one idle cycle before the next byte.
  always_comb begin
    state_d    = state_q;
    addr_d     = addr_q;
    rem_d      = rem_q;
    poll_d     = poll_q;
    gap_d      = gap_q;
    timeout_d  = timeout_q;
    rd_data_d  = rd_data_q;
    rd_valid_d = 1'b0;
    done_d     = 1'b0;
    req_d      = req_q;
    tx_d       = tx_q;
    last_d     = last_q;

    case (state_q)
      IDLE: begin
        if (i_start) begin
          addr_d    = i_addr;
          rem_d     = i_len;
          poll_d    = 8'd0;
          timeout_d = 1'b0;
          state_d   = S_CMD;
        end
      end
      S_CMD: begin
        if (!req_q) begin
          req_d = 1'b1; tx_d = 8'h05; last_d = 1'b0;
        end else if (i_xfer_done) begin
          req_d = 1'b0; state_d = S_RSP;
        end
      end
      S_RSP: begin
        if (!req_q) begin
          req_d = 1'b1; tx_d = 8'hFF; last_d = 1'b1;
        end else if (i_xfer_done) begin
          req_d  = 1'b0;
          poll_d = poll_q + 8'd1;
          if (!i_xfer_rx[0]) begin
            if (rem_q != '0) begin
              state_d = R_CMD;
            end else begin
              state_d = FIN; done_d = 1'b1;
            end
          end else if (poll_d == POLL_LAST) begin
            state_d = FIN; done_d = 1'b1; timeout_d = 1'b1;
          end else begin
            state_d = S_GAP; gap_d = '0;
          end
        end
      end
      S_GAP: begin
        // The next status command is raised straight out of the gap so that
        // exactly POLL_GAP cycles pass with req low.
        if (gap_q == GAP_LAST) begin
          state_d = S_CMD; req_d = 1'b1; tx_d = 8'h05; last_d = 1'b0;
        end else begin
          gap_d = gap_q + 1'b1;
        end
      end
      R_CMD: begin
        if (!req_q) begin
          req_d = 1'b1; tx_d = 8'h03; last_d = 1'b0;
        end else if (i_xfer_done) begin
          req_d = 1'b0; state_d = R_A2;
        end
      end
      R_A2: begin
        if (!req_q) begin
          req_d = 1'b1; tx_d = addr_q[23:16]; last_d = 1'b0;
        end else if (i_xfer_done) begin
          req_d = 1'b0; state_d = R_A1;
        end
      end
      R_A1: begin
        if (!req_q) begin
          req_d = 1'b1; tx_d = addr_q[15:8]; last_d = 1'b0;
        end else if (i_xfer_done) begin
          req_d = 1'b0; state_d = R_A0;
        end
      end
      R_A0: begin
        if (!req_q) begin
          req_d = 1'b1; tx_d = addr_q[7:0]; last_d = 1'b0;
        end else if (i_xfer_done) begin
          req_d = 1'b0; state_d = R_DAT;
        end
      end
      R_DAT: begin
        // Done is issued together with the final data byte's valid.
        if (!req_q) begin
          req_d = 1'b1; tx_d = 8'hFF; last_d = (rem_q == LEN_W'(1));
        end else if (i_xfer_done) begin
          req_d      = 1'b0;
          rd_data_d  = i_xfer_rx;
          rd_valid_d = 1'b1;
          rem_d      = rem_q - 1'b1;
          if (rem_q == LEN_W'(1)) begin
            state_d = FIN; done_d = 1'b1;
          end
        end
      end
      FIN: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
        req_d   = 1'b0;
      end
    endcase

    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q    <= IDLE;
      addr_q     <= 24'h0;
      rem_q      <= '0;
      poll_q     <= 8'd0;
      gap_q      <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      timeout_q  <= 1'b0;
      rd_data_q  <= 8'h00;
      rd_valid_q <= 1'b0;
      req_q      <= 1'b0;
      tx_q       <= 8'h00;
      last_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      addr_q     <= addr_d;
      rem_q      <= rem_d;
      poll_q     <= poll_d;
      gap_q      <= gap_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      timeout_q  <= timeout_d;
      rd_data_q  <= rd_data_d;
      rd_valid_q <= rd_valid_d;
      req_q      <= req_d;
      tx_q       <= tx_d;
      last_q     <= last_d;
    end
  end

  assign o_busy      = busy_q;
  assign o_done      = done_q;
  assign o_timeout   = timeout_q;
  assign o_rd_data   = rd_data_q;
  assign o_rd_valid  = rd_valid_q;
  assign o_xfer_req  = req_q;
  assign o_xfer_tx   = tx_q;
  assign o_xfer_last = last_q;

endmodule

// File: tb/tb_spi_flash_rd_seq.sv
// Bench for spi_flash_rd_seq: a behavioural SPI engine plus a transaction-level
// model of the expected byte stream, data, gaps and completion status.
module tb_spi_flash_rd_seq;

  localparam int LEN_W     = 8;
  localparam int POLL_GAP  = 5;
  localparam int MAX_POLLS = 4;

  typedef logic [7:0] bq_t[$];

  logic             i_clk = 1'b0;
  logic             i_rst_n = 1'b0;
  logic             i_start = 1'b0;
  logic [23:0]      i_addr = 24'h0;
  logic [LEN_W-1:0] i_len = '0;
  logic             o_busy, o_done, o_timeout, o_rd_valid;
  logic [7:0]       o_rd_data;
  logic             o_xfer_req, o_xfer_last;
  logic [7:0]       o_xfer_tx;
  logic             i_xfer_done = 1'b0;
  logic [7:0]       i_xfer_rx = 8'h00;

  spi_flash_rd_seq #(.LEN_W(LEN_W), .POLL_GAP(POLL_GAP), .MAX_POLLS(MAX_POLLS)) dut (
    .i_clk(i_clk), .i_rst_n(i_rst_n), .i_start(i_start), .i_addr(i_addr), .i_len(i_len),
    .o_busy(o_busy), .o_done(o_done), .o_timeout(o_timeout),
    .o_rd_data(o_rd_data), .o_rd_valid(o_rd_valid),
    .o_xfer_req(o_xfer_req), .o_xfer_tx(o_xfer_tx), .o_xfer_last(o_xfer_last),
    .i_xfer_done(i_xfer_done), .i_xfer_rx(i_xfer_rx)
  );

  initial forever #5 i_clk = ~i_clk;

  int n_checks = 0;
  int n_pass = 0;

  bq_t exp_tx, exp_rx, exp_data, obs_tx, obs_data;
  bit  exp_last[$], exp_pgap[$], obs_last[$], obs_stable[$];
  int  obs_gap[$];
  int  eng_delay = 0;
  int  done_cnt = 0;
  bit  obs_timeout = 1'b0;
  bit  valid_at_done = 1'b0;

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
  endtask

  // Engine model: answers each request after eng_delay cycles with the next
  // scripted MISO byte, and throws stray done pulses while req is low.
  initial begin
    int low_run;
    logic [7:0] tx;
    bit last, stable, aborted;
    low_run = 0;
    forever begin
      @(negedge i_clk);
      if (!i_rst_n) begin
        low_run = 0;
        i_xfer_done = 1'b0;
      end else if (!o_xfer_req) begin
        low_run++;
        i_xfer_done = ($urandom_range(0, 3) == 0);
        i_xfer_rx = 8'($urandom);
      end else begin
        i_xfer_done = 1'b0;
        tx = o_xfer_tx; last = o_xfer_last; stable = 1'b1; aborted = 1'b0;
        obs_tx.push_back(tx); obs_last.push_back(last); obs_gap.push_back(low_run);
        for (int k = 0; k < eng_delay; k++) begin
          @(negedge i_clk);
          if (!i_rst_n) begin aborted = 1'b1; break; end
          if (!o_xfer_req || o_xfer_tx !== tx || o_xfer_last !== last) stable = 1'b0;
        end
        if (aborted) begin
          low_run = 0;
        end else begin
          i_xfer_rx = (exp_rx.size() > 0) ? exp_rx.pop_front() : 8'h00;
          i_xfer_done = 1'b1;
          @(negedge i_clk);
          i_xfer_done = 1'b0;
          i_xfer_rx = 8'($urandom);
          obs_stable.push_back(stable);
          low_run = o_xfer_req ? 0 : 1;
        end
      end
    end
  end

  initial begin
    forever begin
      @(negedge i_clk);
      if (i_rst_n) begin
        if (o_rd_valid) obs_data.push_back(o_rd_data);
        if (o_done) begin
          done_cnt++;
          obs_timeout = o_timeout;
          valid_at_done = o_rd_valid;
        end
      end
    end
  end

  // Builds the expected transaction from the polling/read rules, runs one
  // operation and compares everything the engine and consumer observed.
  task automatic applyStimulus(input logic [23:0] addr, input logic [7:0] len,
                               input bq_t st, input bq_t data, input int delay, input bit extra);
    int polls;
    bit ok, exp_to, seen;
    logic [7:0] s;
    exp_tx.delete(); exp_rx.delete(); exp_data.delete(); exp_last.delete(); exp_pgap.delete();
    obs_tx.delete(); obs_last.delete(); obs_gap.delete(); obs_stable.delete(); obs_data.delete();
    done_cnt = 0; polls = 0; ok = 1'b0; exp_to = 1'b0;
    while (!ok && !exp_to) begin
      s = (polls < st.size()) ? st[polls] : 8'h00;
      exp_tx.push_back(8'h05); exp_last.push_back(1'b0); exp_rx.push_back(8'($urandom));
      exp_pgap.push_back(polls > 0);
      exp_tx.push_back(8'hFF); exp_last.push_back(1'b1); exp_rx.push_back(s);
      exp_pgap.push_back(1'b0);
      polls++;
      if (!s[0]) ok = 1'b1;
      else if (polls == MAX_POLLS) exp_to = 1'b1;
    end
    if (ok && len != 0) begin
      exp_tx.push_back(8'h03);        exp_tx.push_back(addr[23:16]);
      exp_tx.push_back(addr[15:8]);   exp_tx.push_back(addr[7:0]);
      for (int i = 0; i < 4; i++) begin
        exp_last.push_back(1'b0); exp_pgap.push_back(1'b0); exp_rx.push_back(8'($urandom));
      end
      for (int i = 0; i < int'(len); i++) begin
        exp_tx.push_back(8'hFF); exp_last.push_back(i == int'(len) - 1);
        exp_pgap.push_back(1'b0); exp_rx.push_back(data[i]); exp_data.push_back(data[i]);
      end
    end

    eng_delay = delay;
    @(negedge i_clk);
    i_addr = addr; i_len = len; i_start = 1'b1;
    @(negedge i_clk);
    i_start = 1'b0; i_addr = 24'($urandom); i_len = 8'($urandom);
    seen = 1'b0;
    for (int c = 0; c < 3000 && !seen; c++) begin
      @(negedge i_clk); #1;
      if (extra && c == 3) begin
        i_start = 1'b1; i_addr = ~addr; i_len = len + 8'd1;
      end else begin
        i_start = 1'b0;
      end
      if (done_cnt > 0) seen = 1'b1;
    end
    i_start = 1'b0;
    checkOutput("done_seen", seen, 1);
    repeat (3) @(negedge i_clk);
    #1;
    checkOutput("done_count", done_cnt, 1);
    checkOutput("timeout_at_done", obs_timeout, exp_to);
    checkOutput("timeout_sticky", o_timeout, exp_to);
    checkOutput("busy_after", o_busy, 0);
    checkOutput("valid_with_done", valid_at_done, ok && len != 0);
    checkOutput("byte_count", obs_tx.size(), exp_tx.size());
    for (int i = 0; i < obs_tx.size() && i < exp_tx.size(); i++) begin
      checkOutput($sformatf("tx[%0d]", i), obs_tx[i], exp_tx[i]);
      checkOutput($sformatf("last[%0d]", i), obs_last[i], exp_last[i]);
      if (i < obs_stable.size()) checkOutput($sformatf("stable[%0d]", i), obs_stable[i], 1);
      if (exp_pgap[i]) checkOutput($sformatf("poll_gap[%0d]", i), obs_gap[i], POLL_GAP);
      else checkOutput($sformatf("req_gap[%0d]", i), obs_gap[i] >= 1, 1);
    end
    checkOutput("data_count", obs_data.size(), exp_data.size());
    for (int i = 0; i < obs_data.size() && i < exp_data.size(); i++)
      checkOutput($sformatf("data[%0d]", i), obs_data[i], exp_data[i]);
  endtask

  initial begin
    bq_t st, data;
    bit found;
    logic [7:0] len;
    int nb;

    repeat (3) @(negedge i_clk);
    checkOutput("reset_outputs", {o_busy, o_done, o_timeout, o_rd_data, o_rd_valid,
                                  o_xfer_req, o_xfer_tx, o_xfer_last}, 0);
    i_rst_n = 1'b1;
    repeat (2) @(negedge i_clk);

    $display("[TB] directed read, ready on first poll");
    st = '{8'h00}; data = '{8'hA1, 8'hB2, 8'hC3};
    applyStimulus(24'h012345, 8'd3, st, data, 0, 1'b0);

    $display("[TB] two busy polls then ready");
    st = '{8'h01, 8'h01, 8'h00}; data = '{8'h5A, 8'hC3};
    applyStimulus(24'hFEDCBA, 8'd2, st, data, 1, 1'b0);

    $display("[TB] WIP stuck, timeout");
    st = '{8'h03, 8'h03, 8'h03, 8'h03}; data = '{8'h11, 8'h22};
    applyStimulus(24'h000100, 8'd2, st, data, 0, 1'b0);

    $display("[TB] status check only");
    st = '{8'h00}; data.delete();
    applyStimulus(24'h777777, 8'd0, st, data, 0, 1'b0);

    $display("[TB] slow engine with start while busy");
    st = '{8'h01, 8'h00}; data = '{8'h01, 8'h80, 8'hFF, 8'h00};
    applyStimulus(24'h800001, 8'd4, st, data, 20, 1'b1);

    $display("[TB] reset during address phase");
    exp_rx.delete(); obs_tx.delete(); obs_last.delete(); obs_gap.delete(); obs_stable.delete();
    for (int i = 0; i < 8; i++) exp_rx.push_back(8'h00);
    done_cnt = 0; eng_delay = 20;
    @(negedge i_clk);
    i_addr = 24'hABCDEF; i_len = 8'd3; i_start = 1'b1;
    @(negedge i_clk);
    i_start = 1'b0;
    found = 1'b0;
    for (int c = 0; c < 2000 && !found; c++) begin
      @(negedge i_clk); #1;
      if (obs_tx.size() == 5 && o_xfer_req) found = 1'b1;
    end
    checkOutput("reach_a1", found, 1);
    if (found) checkOutput("a1_byte", obs_tx[4], 8'hCD);
    #2 i_rst_n = 1'b0;
    #1;
    checkOutput("reset_req_async", o_xfer_req, 0);
    checkOutput("reset_mid_outputs", {o_busy, o_done, o_timeout, o_rd_data, o_rd_valid,
                                      o_xfer_req, o_xfer_tx, o_xfer_last}, 0);
    repeat (4) @(negedge i_clk);
    checkOutput("no_done_on_reset", done_cnt, 0);
    i_rst_n = 1'b1;
    repeat (2) @(negedge i_clk);
    st = '{8'h00}; data = '{8'h3C, 8'h96, 8'h69};
    applyStimulus(24'hABCDEF, 8'd3, st, data, 2, 1'b0);

    $display("[TB] randomized operations");
    for (int t = 0; t < 12; t++) begin
      st.delete(); data.delete();
      nb = $urandom_range(0, MAX_POLLS);
      for (int i = 0; i < nb; i++) st.push_back(8'($urandom) | 8'h01);
      st.push_back(8'($urandom) & 8'hFE);
      len = (t == 5) ? 8'd255 : 8'($urandom_range(0, 8));
      for (int i = 0; i < int'(len); i++) data.push_back(8'($urandom));
      applyStimulus(24'($urandom), len, st, data, (t == 5) ? 0 : $urandom_range(0, 3),
                    1'($urandom_range(0, 1)));
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
